// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// o_ovf exists only when NSA_OVF_FLAG_EN is defined.
interface nibble_serial_adder_if #(
    parameter int N_NIBBLES = 4
);
    localparam int W = 4 * N_NIBBLES;

    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_c_in;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_sum;
    logic         o_cout;
`ifdef NSA_OVF_FLAG_EN
    logic         o_ovf;

    modport slave (
        input  i_valid, i_a, i_b, i_c_in, i_ready,
        output o_ready, o_valid, o_sum, o_cout, o_ovf
    );

    modport master (
        output i_valid, i_a, i_b, i_c_in, i_ready,
        input  o_ready, o_valid, o_sum, o_cout, o_ovf
    );
`else
    modport slave (
        input  i_valid, i_a, i_b, i_c_in, i_ready,
        output o_ready, o_valid, o_sum, o_cout
    );

    modport master (
        output i_valid, i_a, i_b, i_c_in, i_ready,
        input  o_ready, o_valid, o_sum, o_cout
    );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit ripple adder, one nibble per clock.
// Optional signed-overflow flag is enabled by defining NSA_OVF_FLAG_EN.
module full_adder_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c_in,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_c_in};
endmodule

module nibble_serial_adder #(
    parameter int N_NIBBLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    nibble_serial_adder_if.slave   bus
);
    localparam int W     = 4 * N_NIBBLES;
    localparam int IDX_W = $clog2(N_NIBBLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [W-1:0]       sum_r;
    logic               cout_r;
    logic               last_s;
    logic [3:0]         fa_a_s;
    logic [3:0]         fa_b_s;
    logic [3:0]         fa_sum_s;
    logic               fa_cout_s;

    assign last_s = (idx_r == IDX_W'(N_NIBBLES - 1));
    assign fa_a_s = a_r[4*idx_r +: 4];
    assign fa_b_s = b_r[4*idx_r +: 4];

    full_adder_4bit u_fa (
        .i_a    (fa_a_s),
        .i_b    (fa_b_s),
        .i_c_in (carry_r),
        .o_sum  (fa_sum_s),
        .o_cout (fa_cout_s)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; handshake inputs only steer transitions
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_valid) state_s = ST_RUN;
                else             state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_RUN;
            end
            ST_DONE: begin
                if (bus.i_ready) state_s = ST_IDLE;
                else             state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand latch and nibble-serial accumulation; carry crosses nibbles only via carry_r
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            sum_r   <= {W{1'b0}};
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        a_r     <= bus.i_a;
                        b_r     <= bus.i_b;
                        carry_r <= bus.i_c_in;
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    sum_r[4*idx_r +: 4] <= fa_sum_s;
                    carry_r             <= fa_cout_s;
                    if (last_s) begin
                        cout_r <= fa_cout_s;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef NSA_OVF_FLAG_EN
    logic ovf_r;

    // Signed overflow: like-signed operands whose top result bit differs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_r <= 1'b0;
        end else if (state_r == ST_RUN && last_s) begin
            ovf_r <= (a_r[W-1] == b_r[W-1]) && (fa_sum_s[3] != a_r[W-1]);
        end
    end

    assign bus.o_ovf = ovf_r;
`endif

    assign bus.o_ready = (state_r == ST_IDLE);
    assign bus.o_valid = (state_r == ST_DONE);
    assign bus.o_sum   = sum_r;
    assign bus.o_cout  = cout_r;

endmodule
